// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - operation codes and FSM states for the sequential shifter
package shift_pkg;

  localparam logic [1:0] ALUC_SRA = 2'b00;
  localparam logic [1:0] ALUC_SRL = 2'b10;
  localparam logic [1:0] ALUC_SLL = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step32.sv
// rtl/shift_step32.sv - one combinational shift step of 1 or 4 bits
module shift_step32
  import shift_pkg::*;
(
  input  logic [31:0] shreg,
  input  logic [1:0]  op,
  input  logic        by4,
  output logic [31:0] res
);

  always_comb begin
    res = shreg;
    case (op)
      ALUC_SRA: res = by4 ? {{4{shreg[31]}}, shreg[31:4]} : {shreg[31], shreg[31:1]};
      ALUC_SRL: res = by4 ? {4'b0000, shreg[31:4]} : {1'b0, shreg[31:1]};
      // 2'b01 and 2'b11 both mean left shift
      default:  res = by4 ? {shreg[27:0], 4'b0000} : {shreg[30:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/shifter32_seq.sv
// rtl/shifter32_seq.sv - multi-cycle 32-bit shifter with start/busy/done handshake
module shifter32_seq
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [4:0]  b,
  input  logic [1:0]  aluc,
  output logic        busy,
  output logic        done,
  output logic [31:0] c
);

  state_t      state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] c_q, c_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        by4;
  logic [31:0] step_res;

  assign by4 = (cnt_q >= 5'd4);

  shift_step32 u_step (
    .shreg (shreg_q),
    .op    (op_q),
    .by4   (by4),
    .res   (step_res)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d = a;
          cnt_d   = b;
          op_d    = aluc;
          if (b == 5'd0) begin
            c_d     = a;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        shreg_d = step_res;
        cnt_d   = cnt_q - (by4 ? 5'd4 : 5'd1);
        if (cnt_d == 5'd0) begin
          c_d     = step_res;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // outputs are registered from the next state so they line up with it
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= 32'h0;
      cnt_q   <= 5'd0;
      op_q    <= ALUC_SRA;
      c_q     <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign c    = c_q;

endmodule

// File: tb/tb_shifter32_seq.sv
// tb/tb_shifter32_seq.sv - scoreboard bench for shifter32_seq against a reference shift model
module tb_shifter32_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'h0;
  logic [4:0]  b = 5'd0;
  logic [1:0]  aluc = 2'b00;
  logic        busy;
  logic        done;
  logic [31:0] c;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];

  shifter32_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .aluc  (aluc),
    .busy  (busy),
    .done  (done),
    .c     (c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] n,
                                            input logic [1:0] op);
    int unsigned sh;
    sh = n;
    if (op == 2'b00) return 32'($signed(x) >>> sh);
    if (op == 2'b10) return x >> sh;
    return x << sh;
  endfunction

  function automatic int steps(input logic [4:0] n);
    return (int'(n) / 4) + (int'(n) % 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: done at cycle %0d with c=%h, none expected", cyc, c);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_c", c, e.res);
        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  // issue one operation; junk=1 keeps hammering start with other operands while busy
  task automatic run_op(input logic [31:0] ia, input logic [4:0] ib, input logic [1:0] iop,
                        input bit junk);
    exp_t e;
    int guard;
    a = ia;
    b = ib;
    aluc = iop;
    start = 1'b1;
    e.res = ref_shift(ia, ib, iop);
    e.done_cyc = cyc + steps(ib) + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    forever begin
      check("busy_during_op", 32'(busy), 32'd1);
      if (done === 1'b1) break;
      if (guard > 14) begin
        total++;
        bad++;
        $display("FAIL done_timeout: no done within %0d cycles, expected 0x%h", guard, e.res);
        break;
      end
      if (junk) begin
        start = 1'b1;
        a = $urandom;
        b = 5'($urandom);
        aluc = 2'($urandom);
      end
      guard++;
      @(negedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_after_done", 32'(done), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_c", c, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'h80000000, 5'd31, 2'b00, 1'b0);
    check("sra_sign_fill", c, 32'hFFFFFFFF);
    run_op(32'h80000000, 5'd31, 2'b10, 1'b0);
    check("srl_zero_fill", c, 32'h00000001);
    run_op(32'h00000001, 5'd5, 2'b11, 1'b0);
    check("sll_mixed", c, 32'h00000020);
    run_op(32'h12345678, 5'd0, 2'b01, 1'b0);
    check("b_zero", c, 32'h12345678);
    run_op(32'h7FFFFFF0, 5'd4, 2'b00, 1'b0);
    check("sra_positive", c, 32'h07FFFFFF);
    run_op(32'hF0000000, 5'd8, 2'b10, 1'b1);
    check("start_while_busy", c, 32'h00F00000);

    // reset in the middle of a b=31 shift
    a = 32'hDEADBEEF;
    b = 5'd31;
    aluc = 2'b10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_c", c, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      check("post_rst_idle_busy", 32'(busy), 32'd0);
    end
    run_op(32'hA5A5A5A5, 5'd13, 2'b00, 1'b0);

    for (int i = 0; i < 200; i++) begin
      run_op($urandom, 5'($urandom), 2'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_expectations: %0d outstanding, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
